// File: rtl/user_cmd_capture.sv
// user_cmd_capture
// Front-end command stage ahead of bus master 1. Debounces the two active-low
// push buttons and turns each press into a single-cycle pulse. In
// configuration mode a load press stores switch_array into the next
// configuration slot. In run mode a start press latches one read/write
// command, offers it over a valid/ready handshake, then follows the master's
// busy flag until the transaction is finished.
//
// Ports
//   clock_i          system clock (single domain)
//   rst_i            synchronous active-high reset
//   enable_i         global clock enable, 0 freezes every register
//   start_raw_i      raw start button, active-low, asynchronous
//   load_raw_i       raw configuration-load button, active-low, asynchronous
//   mode_switch_i    0 = configuration mode, 1 = run mode
//   rw_switch_i      0 = write, 1 = read
//   switch_array_i   configuration value
//   m_busy_i         master busy flag
//   cmd_ready_i      master accepts the offered command
//   cmd_valid_o      command offered
//   cmd_rw_o         latched read/write select
//   cmd_addr_o       latched address
//   cmd_wdata_o      latched write data
//   cmd_burst_o      latched burst length, 0 = single transfer
//   cfg_index_o      next configuration slot (0 addr, 1 wdata, 2 burst)
//   ctrl_busy_o      high whenever the controller is not idle
module user_cmd_capture #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int BUSY_TIMEOUT    = 15
) (
  input  logic                  clock_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  start_raw_i,
  input  logic                  load_raw_i,
  input  logic                  mode_switch_i,
  input  logic                  rw_switch_i,
  input  logic [11:0]           switch_array_i,
  input  logic                  m_busy_i,
  input  logic                  cmd_ready_i,
  output logic                  cmd_valid_o,
  output logic                  cmd_rw_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_wdata_o,
  output logic [11:0]           cmd_burst_o,
  output logic [1:0]            cfg_index_o,
  output logic                  ctrl_busy_o
);

  localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ToW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(BUSY_TIMEOUT - 1);

  // Button index 0 is start, index 1 is load.
  logic [1:0] rawBtn;
  assign rawBtn = {load_raw_i, start_raw_i};

  logic [1:0]     sync1_q, sync2_q, level_q, levelPrev_q, pulse_q;
  logic [1:0]     level_d;
  logic [DbW-1:0] dbCnt_q [2];
  logic [DbW-1:0] dbCnt_d [2];

  logic startPulse, loadPulse;
  assign startPulse = pulse_q[0];
  assign loadPulse  = pulse_q[1];

  // Debounce next state: the counter only runs while the synchronized value
  // disagrees with the accepted level, so any bounce back clears it.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      level_d[b] = level_q[b];
      dbCnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (dbCnt_q[b] == DbLast) begin
          level_d[b] = sync2_q[b];
        end else begin
          dbCnt_d[b] = dbCnt_q[b] + DbW'(1);
        end
      end
    end
  end

  // Synchronizers, debounced levels and the press pulse register. The pulse
  // compares the previous and current debounced level so it lands one edge
  // after the level flips, and only on a 1->0 change.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      level_q     <= '1;
      levelPrev_q <= '1;
      pulse_q     <= '0;
      for (int b = 0; b < 2; b++) dbCnt_q[b] <= '0;
    end else if (enable_i) begin
      sync1_q     <= rawBtn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      pulse_q     <= levelPrev_q & ~level_q;
      for (int b = 0; b < 2; b++) dbCnt_q[b] <= dbCnt_d[b];
    end
  end

  logic [ADDR_WIDTH-1:0] cfgAddr_q;
  logic [DATA_WIDTH-1:0] cfgWdata_q;
  logic [11:0]           cfgBurst_q;
  logic [1:0]            cfgIndex_q;

  // Configuration slots, filled round-robin by load presses in config mode.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      cfgAddr_q  <= '0;
      cfgWdata_q <= '0;
      cfgBurst_q <= '0;
      cfgIndex_q <= '0;
    end else if (enable_i && loadPulse && !mode_switch_i) begin
      case (cfgIndex_q)
        2'd0:    cfgAddr_q  <= switch_array_i[ADDR_WIDTH-1:0];
        2'd1:    cfgWdata_q <= switch_array_i[DATA_WIDTH-1:0];
        default: cfgBurst_q <= switch_array_i;
      endcase
      cfgIndex_q <= (cfgIndex_q == 2'd2) ? 2'd0 : cfgIndex_q + 2'd1;
    end
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [ToW-1:0]        timer_q;
  logic                  cmdValid_q, cmdRw_q, ctrlBusy_q;
  logic [ADDR_WIDTH-1:0] cmdAddr_q;
  logic [DATA_WIDTH-1:0] cmdWdata_q;
  logic [11:0]           cmdBurst_q;

  // Command FSM with registered outputs. Start presses are only honoured in
  // IDLE; the command fields are latched once on acceptance and stay put
  // until the next accepted start.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cmdValid_q <= 1'b0;
      cmdRw_q    <= 1'b0;
      cmdAddr_q  <= '0;
      cmdWdata_q <= '0;
      cmdBurst_q <= '0;
      ctrlBusy_q <= 1'b0;
    end else if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (startPulse && mode_switch_i && !m_busy_i) begin
            cmdRw_q    <= rw_switch_i;
            cmdAddr_q  <= cfgAddr_q;
            cmdWdata_q <= cfgWdata_q;
            cmdBurst_q <= cfgBurst_q;
            cmdValid_q <= 1'b1;
            ctrlBusy_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            cmdValid_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Give up if the master never reports busy within the window.
          if (m_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == ToLast) begin
            ctrlBusy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            timer_q <= timer_q + ToW'(1);
          end
        end
        WAIT_DONE: begin
          if (!m_busy_i) begin
            ctrlBusy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid_o = cmdValid_q;
  assign cmd_rw_o    = cmdRw_q;
  assign cmd_addr_o  = cmdAddr_q;
  assign cmd_wdata_o = cmdWdata_q;
  assign cmd_burst_o = cmdBurst_q;
  assign cfg_index_o = cfgIndex_q;
  assign ctrl_busy_o = ctrlBusy_q;

endmodule
